i2c_bus_arbiter: RTL and testbench

- Shares one I2C byte controller (start/stop/read/write/ack_in/din, cmd_ack/dout/busy/al) between NUM_REQ requesters, e.g. the Si5340 config loader, a monitor and a status poller.
- Grants are round-robin at transaction granularity. A transaction runs from the owner's first command to the completion of a command carrying stop.
- Adds a per-command watchdog and arbitration-loss abort, so a hung or lost bus never locks out the other requesters.

---
 rtl/i2c_bus_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// Round-robin sharing of one I2C byte controller between NUM_REQ requesters at
// transaction granularity, with a per-command watchdog and arbitration-loss abort.
module i2c_bus_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                          clk_i,
    input  logic                          arst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    input  logic [NUM_REQ-1:0]            cmd_valid_i,
    output logic [NUM_REQ-1:0]            cmd_ready_o,
    input  logic [NUM_REQ-1:0]            cmd_start_i,
    input  logic [NUM_REQ-1:0]            cmd_stop_i,
    input  logic [NUM_REQ-1:0]            cmd_read_i,
    input  logic [NUM_REQ-1:0]            cmd_write_i,
    input  logic [NUM_REQ-1:0]            cmd_ack_in_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] cmd_din_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_dout_o,
    output logic [NUM_REQ-1:0]            rsp_err_o,
    output logic                          start_o,
    output logic                          stop_o,
    output logic                          read_o,
    output logic                          write_o,
    output logic                          ack_in_o,
    output logic [DATA_WIDTH-1:0]         din_o,
    input  logic                          cmd_ack_i,
    input  logic [DATA_WIDTH-1:0]         dout_i,
    input  logic                          i2c_al_i,
    input  logic                          i2c_busy_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0]    WD_MAX   = WD_W'(TIMEOUT_CYC);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GRANT      = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_WAIT_ACK   = 3'd3,
        ST_ABORT_STOP = 3'd4,
        ST_WAIT_STOP  = 3'd5
    } state_t;

    state_t                  state_r;
    logic [IDX_W-1:0]        rr_r;
    logic [IDX_W-1:0]        owner_r;
    logic [WD_W-1:0]         wdog_r;
    logic                    drop_r;
    logic [IDX_W-1:0]        pick_s;
    logic                    any_req_s;
    logic [DATA_WIDTH-1:0]   din_sel_s;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_REQ - 1)) begin
            next_idx = {IDX_W{1'b0}};
        end else begin
            next_idx = idx + IDX_W'(1);
        end
    endfunction

    // Round-robin pick: first requesting index at or after the rr pointer, wrapping.
    always_comb begin : pick_comb
        logic             found_v;
        logic [IDX_W:0]   cand_v;
        found_v   = 1'b0;
        cand_v    = {(IDX_W+1){1'b0}};
        pick_s    = rr_r;
        any_req_s = |req_i;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_v = {1'b0, rr_r} + (IDX_W+1)'(i);
            if (cand_v >= (IDX_W+1)'(NUM_REQ)) begin
                cand_v = cand_v - (IDX_W+1)'(NUM_REQ);
            end else begin
                cand_v = cand_v;
            end
            if (!found_v && req_i[cand_v[IDX_W-1:0]]) begin
                found_v = 1'b1;
                pick_s  = cand_v[IDX_W-1:0];
            end else begin
                found_v = found_v;
            end
        end
    end

    // Write byte of the current owner.
    always_comb begin
        din_sel_s = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_r == IDX_W'(k)) begin
                din_sel_s = cmd_din_i[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                din_sel_s = din_sel_s;
            end
        end
    end

    // Transaction FSM with registered grant, handshake, controller and response outputs.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_r     <= ST_IDLE;
            rr_r        <= {IDX_W{1'b0}};
            owner_r     <= {IDX_W{1'b0}};
            wdog_r      <= {WD_W{1'b0}};
            drop_r      <= 1'b0;
            gnt_o       <= {NUM_REQ{1'b0}};
            cmd_ready_o <= {NUM_REQ{1'b0}};
            rsp_valid_o <= {NUM_REQ{1'b0}};
            rsp_err_o   <= {NUM_REQ{1'b0}};
            rsp_dout_o  <= {DATA_WIDTH{1'b0}};
            start_o     <= 1'b0;
            stop_o      <= 1'b0;
            read_o      <= 1'b0;
            write_o     <= 1'b0;
            ack_in_o    <= 1'b0;
            din_o       <= {DATA_WIDTH{1'b0}};
        end else begin
            rsp_valid_o <= {NUM_REQ{1'b0}};
            rsp_err_o   <= {NUM_REQ{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    drop_r <= 1'b0;
                    if (any_req_s && !i2c_busy_i) begin
                        owner_r     <= pick_s;
                        gnt_o       <= ONE_HOT0 << pick_s;
                        cmd_ready_o <= ONE_HOT0 << pick_s;
                        state_r     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Command is driven straight into the output registers so it appears one cycle after accept.
                    if (cmd_valid_i[owner_r]) begin
                        start_o     <= cmd_start_i[owner_r];
                        stop_o      <= cmd_stop_i[owner_r];
                        read_o      <= cmd_read_i[owner_r];
                        write_o     <= cmd_write_i[owner_r];
                        ack_in_o    <= cmd_ack_in_i[owner_r];
                        din_o       <= din_sel_s;
                        cmd_ready_o <= {NUM_REQ{1'b0}};
                        state_r     <= ST_ISSUE;
                    end else if (!req_i[owner_r]) begin
                        gnt_o       <= {NUM_REQ{1'b0}};
                        cmd_ready_o <= {NUM_REQ{1'b0}};
                        rr_r        <= next_idx(owner_r);
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    wdog_r  <= {WD_W{1'b0}};
                    drop_r  <= drop_r | ~req_i[owner_r];
                    state_r <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (i2c_al_i) begin
                        rsp_err_o   <= gnt_o;
                        start_o     <= 1'b0;
                        stop_o      <= 1'b0;
                        read_o      <= 1'b0;
                        write_o     <= 1'b0;
                        ack_in_o    <= 1'b0;
                        din_o       <= {DATA_WIDTH{1'b0}};
                        gnt_o       <= {NUM_REQ{1'b0}};
                        rr_r        <= next_idx(owner_r);
                        state_r     <= ST_IDLE;
                    end else if (cmd_ack_i) begin
                        rsp_valid_o <= gnt_o;
                        rsp_dout_o  <= dout_i;
                        start_o     <= 1'b0;
                        stop_o      <= 1'b0;
                        read_o      <= 1'b0;
                        write_o     <= 1'b0;
                        ack_in_o    <= 1'b0;
                        din_o       <= {DATA_WIDTH{1'b0}};
                        if (stop_o) begin
                            gnt_o   <= {NUM_REQ{1'b0}};
                            rr_r    <= next_idx(owner_r);
                            state_r <= ST_IDLE;
                        end else if (drop_r || !req_i[owner_r]) begin
                            state_r <= ST_ABORT_STOP;
                        end else begin
                            cmd_ready_o <= gnt_o;
                            state_r     <= ST_GRANT;
                        end
                    end else if (wdog_r == WD_MAX) begin
                        rsp_err_o <= gnt_o;
                        start_o   <= 1'b0;
                        stop_o    <= 1'b0;
                        read_o    <= 1'b0;
                        write_o   <= 1'b0;
                        ack_in_o  <= 1'b0;
                        din_o     <= {DATA_WIDTH{1'b0}};
                        state_r   <= ST_ABORT_STOP;
                    end else begin
                        wdog_r <= wdog_r + WD_W'(1);
                        drop_r <= drop_r | ~req_i[owner_r];
                    end
                end
                ST_ABORT_STOP: begin
                    stop_o  <= 1'b1;
                    wdog_r  <= {WD_W{1'b0}};
                    state_r <= ST_WAIT_STOP;
                end
                ST_WAIT_STOP: begin
                    // The recovery stop is internal: it never produces a response to the owner.
                    if (cmd_ack_i || i2c_al_i || (wdog_r == WD_MAX)) begin
                        stop_o  <= 1'b0;
                        gnt_o   <= {NUM_REQ{1'b0}};
                        rr_r    <= next_idx(owner_r);
                        state_r <= ST_IDLE;
                    end else begin
                        wdog_r <= wdog_r + WD_W'(1);
                    end
                end
                default: begin
                    gnt_o       <= {NUM_REQ{1'b0}};
                    cmd_ready_o <= {NUM_REQ{1'b0}};
                    start_o     <= 1'b0;
                    stop_o      <= 1'b0;
                    read_o      <= 1'b0;
                    write_o     <= 1'b0;
                    ack_in_o    <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench: directed scenarios plus randomized transactions against a
// transaction-level round-robin model of the arbiter.
module tb_i2c_bus_arbiter;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            clk_i = 1'b0;
    logic            arst_i;
    logic [N-1:0]    req_i, gnt_o, cmd_valid_i, cmd_ready_o;
    logic [N-1:0]    cmd_start_i, cmd_stop_i, cmd_read_i, cmd_write_i, cmd_ack_in_i;
    logic [N*DW-1:0] cmd_din_i;
    logic [N-1:0]    rsp_valid_o, rsp_err_o;
    logic [DW-1:0]   rsp_dout_o, din_o, dout_i;
    logic            start_o, stop_o, read_o, write_o, ack_in_o;
    logic            cmd_ack_i, i2c_al_i, i2c_busy_i;

    int n_chk  = 0;
    int n_pass = 0;
    int rr_m   = 0;

    i2c_bus_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk_i), .arst_i(arst_i), .req_i(req_i), .gnt_o(gnt_o),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_start_i(cmd_start_i), .cmd_stop_i(cmd_stop_i), .cmd_read_i(cmd_read_i),
        .cmd_write_i(cmd_write_i), .cmd_ack_in_i(cmd_ack_in_i), .cmd_din_i(cmd_din_i),
        .rsp_valid_o(rsp_valid_o), .rsp_dout_o(rsp_dout_o), .rsp_err_o(rsp_err_o),
        .start_o(start_o), .stop_o(stop_o), .read_o(read_o), .write_o(write_o),
        .ack_in_o(ack_in_o), .din_o(din_o), .cmd_ack_i(cmd_ack_i), .dout_i(dout_i),
        .i2c_al_i(i2c_al_i), .i2c_busy_i(i2c_busy_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    // Model: first requester at or after the rr pointer, wrapping.
    function automatic int rr_pick(input logic [N-1:0] mask, input int rr);
        for (int i = 0; i < N; i++) begin
            if (mask[(rr + i) % N]) return (rr + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int o);
        logic [N-1:0] v;
        v = '0;
        v[o] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        arst_i = 1'b1; req_i = '0; cmd_valid_i = '0; cmd_start_i = '0; cmd_stop_i = '0;
        cmd_read_i = '0; cmd_write_i = '0; cmd_ack_in_i = '0; cmd_din_i = '0;
        cmd_ack_i = 1'b0; i2c_al_i = 1'b0; i2c_busy_i = 1'b0; dout_i = '0;
        step();
        step();
        arst_i = 1'b0;
        rr_m = 0;
    endtask

    task automatic wait_gnt(input int o);
        for (int n = 0; n < 40; n++) begin
            step();
            if (gnt_o != '0) break;
        end
        chk_eq("grant", gnt_o, oh(o));
        chk_eq("ready_owner_only", cmd_ready_o, oh(o));
    endtask

    // Present one command and check it reaches the byte controller one cycle after accept.
    task automatic issue(input int o, input bit st, input bit sp, input bit rd,
                         input bit wr, input bit ak, input logic [7:0] d);
        for (int n = 0; n < 40; n++) begin
            if (cmd_ready_o[o]) break;
            step();
        end
        cmd_valid_i[o] = 1'b1; cmd_start_i[o] = st; cmd_stop_i[o] = sp; cmd_read_i[o] = rd;
        cmd_write_i[o] = wr; cmd_ack_in_i[o] = ak; cmd_din_i[o*DW +: DW] = d;
        step();
        cmd_valid_i[o] = 1'b0;
        chk_eq("issue_outputs", {start_o, stop_o, read_o, write_o, ack_in_o, din_o},
               {st, sp, rd, wr, ak, d});
        chk_eq("ready_low_after_accept", cmd_ready_o, '0);
    endtask

    task automatic reply(input int dly, input bit ack, input bit al, input logic [7:0] dv);
        repeat (dly) step();
        cmd_ack_i = ack; i2c_al_i = al; dout_i = dv;
        step();
        cmd_ack_i = 1'b0; i2c_al_i = 1'b0;
    endtask

    // One command completed normally; the owner sees exactly one response.
    task automatic txn_cmd(input int o, input bit st, input bit sp, input bit rd,
                           input bit wr, input bit ak, input logic [7:0] d,
                           input int dly, input logic [7:0] dv);
        issue(o, st, sp, rd, wr, ak, d);
        reply(dly, 1'b1, 1'b0, dv);
        chk_eq("rsp_valid", rsp_valid_o, oh(o));
        chk_eq("rsp_err_quiet", rsp_err_o, '0);
        chk_eq("rsp_dout", rsp_dout_o, dv);
        chk_eq("cmd_cleared", {start_o, stop_o, read_o, write_o, ack_in_o}, 5'b0);
        chk_eq("grant_after_cmd", gnt_o, sp ? '0 : oh(o));
        if (sp) rr_m = (o + 1) % N;
    endtask

    initial begin
        int n;
        do_reset();
        chk_eq("reset_outputs", {gnt_o, cmd_ready_o, rsp_valid_o, rsp_err_o,
                start_o, stop_o, read_o, write_o, ack_in_o}, '0);
        chk_eq("reset_bytes", {din_o, rsp_dout_o}, '0);

        // Single-owner three-byte write.
        req_i = 3'b001;
        wait_gnt(0);
        txn_cmd(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE8, 2, 8'h00);
        txn_cmd(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1, 8'h00);
        txn_cmd(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0B, 3, 8'h00);
        req_i = '0;

        // Contention from reset, plus the read of 0xA5 by requester 1.
        do_reset();
        req_i = 3'b011;
        wait_gnt(rr_pick(req_i, rr_m));
        txn_cmd(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 2, 8'h00);
        wait_gnt(rr_pick(req_i, rr_m));
        txn_cmd(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 2, 8'hA5);
        wait_gnt(rr_pick(req_i, rr_m));
        txn_cmd(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22, 1, 8'h00);
        req_i = '0;

        // Watchdog timeout, then recovery stop acknowledged.
        req_i = 3'b001;
        wait_gnt(rr_pick(req_i, rr_m));
        issue(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            n = k;
            if (rsp_err_o != '0) break;
        end
        chk_eq("timeout_latency_ok", (n >= TO && n <= TO + 3) ? 32'd1 : 32'd0, 32'd1);
        chk_eq("timeout_err", {rsp_err_o, rsp_valid_o}, {3'b001, 3'b000});
        chk_eq("timeout_cmd_cleared", {start_o, stop_o, write_o}, 3'b000);
        step();
        chk_eq("abort_stop_alone", {start_o, stop_o, read_o, write_o, ack_in_o}, 5'b01000);
        reply(2, 1'b1, 1'b0, 8'h00);
        chk_eq("abort_released", {gnt_o, rsp_valid_o, rsp_err_o, stop_o}, '0);
        rr_m = 1;
        req_i = '0;

        // Owner drops request mid-command: command completes, then a silent recovery stop.
        req_i = 3'b010;
        wait_gnt(rr_pick(req_i, rr_m));
        issue(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33);
        req_i = '0;
        reply(2, 1'b1, 1'b0, 8'h44);
        chk_eq("drop_rsp", {rsp_valid_o, rsp_err_o}, {3'b010, 3'b000});
        step();
        chk_eq("drop_stop_alone", {start_o, stop_o, read_o, write_o, rsp_err_o}, {4'b0100, 3'b000});
        reply(1, 1'b1, 1'b0, 8'h00);
        chk_eq("drop_released", {gnt_o, rsp_valid_o, stop_o}, '0);
        rr_m = 2;

        // Asynchronous reset during WAIT_ACK.
        req_i = 3'b110;
        wait_gnt(rr_pick(req_i, rr_m));
        issue(2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
        step();
        arst_i = 1'b1;
        #1;
        chk_eq("async_reset_outputs", {gnt_o, cmd_ready_o, start_o, stop_o, write_o, din_o}, '0);
        step();
        arst_i = 1'b0;
        rr_m = 0;
        wait_gnt(rr_pick(req_i, rr_m));
        txn_cmd(1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h09, 1, 8'h00);
        req_i = '0;

        // Randomized transactions, occasional bus-busy hold and arbitration loss.
        for (int it = 0; it < 60; it++) begin
            logic [N-1:0] mask;
            int o, ncmd;
            mask = N'($urandom_range(1, 7));
            if ($urandom_range(0, 3) == 0) begin
                i2c_busy_i = 1'b1;
                req_i = mask;
                repeat (3) step();
                chk_eq("busy_hold", gnt_o, '0);
                i2c_busy_i = 1'b0;
            end else begin
                req_i = mask;
            end
            o = rr_pick(mask, rr_m);
            wait_gnt(o);
            cmd_valid_i = N'($urandom) & ~oh(o);
            cmd_start_i = N'($urandom);
            cmd_write_i = N'($urandom);
            ncmd = $urandom_range(1, 3);
            for (int c = 0; c < ncmd; c++) begin
                bit sp, rd, al;
                logic [7:0] d, dv;
                sp = (c == ncmd - 1);
                rd = 1'($urandom);
                al = ($urandom_range(0, 9) == 0);
                d  = 8'($urandom);
                dv = 8'($urandom);
                if (al) begin
                    issue(o, (c == 0), sp, rd, ~rd, 1'($urandom), d);
                    reply($urandom_range(1, 6), 1'($urandom), 1'b1, dv);
                    chk_eq("al_rsp", {rsp_err_o, rsp_valid_o}, {oh(o), 3'b000});
                    chk_eq("al_idle", {gnt_o, stop_o, start_o}, '0);
                    rr_m = (o + 1) % N;
                    break;
                end else begin
                    txn_cmd(o, (c == 0), sp, rd, ~rd, 1'($urandom), d, $urandom_range(1, 6), dv);
                end
            end
            req_i = '0;
            cmd_valid_i = '0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
